// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: opcode classes, forwarding codes and the per-stage shadow record
package pipe_hazard_ctrl_pkg;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam int REC_RD_W = 8;
  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                reg_w;
    logic                is_load;
  } stage_rec_t;
endpackage

// File: rtl/pipe_hazard_ctrl_opc_class.sv
// hz_opc_class: opcode to register-usage class decoder
import pipe_hazard_ctrl_pkg::*;
module hz_opc_class (
  input  logic [6:0] opcode,
  output logic       reg_w,
  output logic       is_load,
  output logic       uses_rs1,
  output logic       uses_rs2
);
  assign reg_w    = opcode == OPC_OP || opcode == OPC_OP_IMM || opcode == OPC_LOAD;
  assign is_load  = opcode == OPC_LOAD;
  assign uses_rs1 = reg_w || opcode == OPC_STORE;
  assign uses_rs2 = opcode == OPC_OP || opcode == OPC_STORE;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stalls, branch flushes and registered EX forwarding selects
import pipe_hazard_ctrl_pkg::*;
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [6:0]             id_opcode,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   ex_branch_taken,
  output logic                   stall,
  output logic                   flush_if_id,
  output logic                   ex_valid,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic                id_reg_w, id_is_load, use_rs1, use_rs2;
  logic [REC_RD_W-1:0] rs1, rs2, rd, mem_rd;
  logic                mem_wr, ex_fw, ex_ld, bubble;
  logic [1:0]          fwd_a_nxt, fwd_b_nxt;
  stage_rec_t          ex_r, id_rec;
  hz_opc_class u_cls (
    .opcode   (id_opcode),
    .reg_w    (id_reg_w),
    .is_load  (id_is_load),
    .uses_rs1 (use_rs1),
    .uses_rs2 (use_rs2)
  );
  assign rs1 = REC_RD_W'(id_rs1);
  assign rs2 = REC_RD_W'(id_rs2);
  assign rd  = REC_RD_W'(id_rd);
  assign id_rec = '{valid: id_valid, rd: rd, reg_w: id_reg_w && rd != '0, is_load: id_is_load};
  assign ex_fw = ex_r.valid && ex_r.reg_w && !ex_r.is_load;
  assign ex_ld = ex_r.valid && ex_r.reg_w && ex_r.is_load;
  assign stall = id_valid && ex_ld && !ex_branch_taken &&
                 ((use_rs1 && ex_r.rd == rs1) || (use_rs2 && ex_r.rd == rs2));
  assign flush_if_id = ex_branch_taken;
  assign bubble = stall || ex_branch_taken;
  assign fwd_a_nxt = !use_rs1 ? FWD_RF : (ex_fw && ex_r.rd == rs1) ? FWD_MEM :
                     (mem_wr && mem_rd == rs1) ? FWD_WB : FWD_RF;
  assign fwd_b_nxt = !use_rs2 ? FWD_RF : (ex_fw && ex_r.rd == rs2) ? FWD_MEM :
                     (mem_wr && mem_rd == rs2) ? FWD_WB : FWD_RF;
  assign ex_valid = ex_r.valid;
  // advance the shadow records, inserting a bubble into EX on stall or branch
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r        <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= '0;
      fwd_a_sel   <= FWD_RF;
      fwd_b_sel   <= FWD_RF;
      stall_count <= '0;
    end else begin
      mem_wr    <= ex_r.valid && ex_r.reg_w;
      mem_rd    <= ex_r.rd;
      ex_r      <= bubble ? '0 : id_rec;
      fwd_a_sel <= bubble ? FWD_RF : fwd_a_nxt;
      fwd_b_sel <= bubble ? FWD_RF : fwd_b_nxt;
      if (stall && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for the hazard controller
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;
  localparam logic [6:0] OP = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  logic clk = 0, rst = 1, id_valid = 0, ex_branch_taken = 0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall, flush_if_id, ex_valid, stall2, flush2, ex_valid2;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a2, fwd_b2;
  logic [15:0] stall_count;
  logic [1:0] cnt2;
  int checks = 0, failures = 0;
  typedef struct {
    logic rst, v;
    logic [6:0] op;
    logic [4:0] r1, r2, rd;
    logic br, st, ev;
    logic [1:0] ea, eb;
    int ec;
  } row_t;
  row_t exp_q[$];
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .stall(stall),
    .flush_if_id(flush_if_id), .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
  );
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .stall(stall2),
    .flush_if_id(flush2), .ex_valid(ex_valid2), .fwd_a_sel(fwd_a2),
    .fwd_b_sel(fwd_b2), .stall_count(cnt2)
  );
  function automatic row_t mk(input logic r, v, input logic [6:0] op, input logic [4:0] r1, r2, rd,
                              input logic br, st, ev, input logic [1:0] ea, eb, input int ec);
    row_t x;
    x.rst = r; x.v = v; x.op = op; x.r1 = r1; x.r2 = r2; x.rd = rd;
    x.br = br; x.st = st; x.ev = ev; x.ea = ea; x.eb = eb; x.ec = ec;
    return x;
  endfunction
  task automatic apply(input row_t r);
    @(negedge clk);
    rst = r.rst; id_valid = r.v; id_opcode = r.op; id_rs1 = r.r1; id_rs2 = r.r2;
    id_rd = r.rd; ex_branch_taken = r.br;
    exp_q.push_back(r);
  endtask
  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, OP, 1, 2, 3, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, OP, 5, 5, 5, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (rows[i]) begin
      row_t e;
      apply(rows[i]);
      #1;
      checks++;
      if (stall !== rows[i].st || flush_if_id !== rows[i].br) begin
        failures++;
        $display("FAIL reset.comb row %0d: stall=%b flush=%b want %b %b", i, stall, flush_if_id, rows[i].st, rows[i].br);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({ex_valid, fwd_a_sel, fwd_b_sel} !== {e.ev, e.ea, e.eb} || stall_count !== 16'(e.ec)) begin
        failures++;
        $display("FAIL reset.regs row %0d: ev=%b a=%b b=%b cnt=%0d want %b %b %b %0d", i, ex_valid, fwd_a_sel, fwd_b_sel, stall_count, e.ev, e.ea, e.eb, e.ec);
      end
    end
  endtask
  task automatic test_forwarding();
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 1, 2, 5, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 5, 1, 6, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(0, 1, OP, 1, 2, 5, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, IMM, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 2, 5, 7, 0, 0, 1, 0, 2, 0));
    rows.push_back(mk(0, 1, IMM, 7, 7, 11, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(0, 1, OP, 11, 7, 13, 0, 0, 1, 1, 2, 0));
    rows.push_back(mk(0, 1, OP, 1, 1, 14, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 2, 2, 14, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 14, 0, 15, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(0, 1, IMM, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, IMM, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 15, 15, 16, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 0, OP, 1, 1, 17, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 17, 0, 18, 0, 0, 1, 0, 0, 0));
    foreach (rows[i]) begin
      row_t e;
      apply(rows[i]);
      #1;
      checks++;
      if (stall !== rows[i].st || flush_if_id !== rows[i].br) begin
        failures++;
        $display("FAIL fwd.comb row %0d: stall=%b flush=%b want %b %b", i, stall, flush_if_id, rows[i].st, rows[i].br);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({ex_valid, fwd_a_sel, fwd_b_sel} !== {e.ev, e.ea, e.eb} || stall_count !== 16'(e.ec)) begin
        failures++;
        $display("FAIL fwd.regs row %0d: ev=%b a=%b b=%b cnt=%0d want %b %b %b %0d", i, ex_valid, fwd_a_sel, fwd_b_sel, stall_count, e.ev, e.ea, e.eb, e.ec);
      end
    end
  endtask
  task automatic test_load_use();
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 8, 8, 9, 0, 1, 0, 0, 0, 1));
    rows.push_back(mk(0, 1, OP, 8, 8, 9, 0, 0, 1, 2, 2, 1));
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 1));
    rows.push_back(mk(0, 1, OP, 1, 2, 9, 0, 0, 1, 0, 0, 1));
    rows.push_back(mk(0, 1, LD, 1, 0, 20, 0, 0, 1, 0, 0, 1));
    rows.push_back(mk(0, 1, ST, 1, 20, 0, 0, 1, 0, 0, 0, 2));
    rows.push_back(mk(0, 1, ST, 1, 20, 0, 0, 0, 1, 0, 2, 2));
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 2));
    rows.push_back(mk(0, 1, LD, 8, 0, 9, 0, 1, 0, 0, 0, 3));
    rows.push_back(mk(0, 1, LD, 8, 0, 9, 0, 0, 1, 2, 0, 3));
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 3));
    rows.push_back(mk(0, 1, OP, 8, 8, 9, 1, 0, 0, 0, 0, 3));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 3));
    rows.push_back(mk(0, 0, OP, 8, 8, 9, 0, 0, 0, 0, 0, 3));
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 3));
    rows.push_back(mk(0, 1, BR, 8, 8, 0, 0, 0, 1, 0, 0, 3));
    foreach (rows[i]) begin
      row_t e;
      apply(rows[i]);
      #1;
      checks++;
      if (stall !== rows[i].st || flush_if_id !== rows[i].br || stall2 !== rows[i].st) begin
        failures++;
        $display("FAIL lu.comb row %0d: stall=%b flush=%b want %b %b", i, stall, flush_if_id, rows[i].st, rows[i].br);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({ex_valid, fwd_a_sel, fwd_b_sel} !== {e.ev, e.ea, e.eb} || stall_count !== 16'(e.ec)) begin
        failures++;
        $display("FAIL lu.regs row %0d: ev=%b a=%b b=%b cnt=%0d want %b %b %b %0d", i, ex_valid, fwd_a_sel, fwd_b_sel, stall_count, e.ev, e.ea, e.eb, e.ec);
      end
    end
  endtask
  task automatic test_x0_store();
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, LD, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 1, 2, 3, 0, 0, 1, 1, 0, 0));
    rows.push_back(mk(0, 1, ST, 4, 3, 3, 0, 0, 1, 0, 1, 0));
    rows.push_back(mk(0, 1, OP, 3, 0, 10, 0, 0, 1, 2, 0, 0));
    foreach (rows[i]) begin
      row_t e;
      apply(rows[i]);
      #1;
      checks++;
      if (stall !== rows[i].st || flush_if_id !== rows[i].br) begin
        failures++;
        $display("FAIL x0st.comb row %0d: stall=%b flush=%b want %b %b", i, stall, flush_if_id, rows[i].st, rows[i].br);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({ex_valid, fwd_a_sel, fwd_b_sel} !== {e.ev, e.ea, e.eb} || stall_count !== 16'(e.ec)) begin
        failures++;
        $display("FAIL x0st.regs row %0d: ev=%b a=%b b=%b cnt=%0d want %b %b %b %0d", i, ex_valid, fwd_a_sel, fwd_b_sel, stall_count, e.ev, e.ea, e.eb, e.ec);
      end
    end
  endtask
  task automatic test_saturation_reset();
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, k));
      rows.push_back(mk(0, 1, OP, 8, 8, 9, 0, 1, 0, 0, 0, k + 1));
      rows.push_back(mk(0, 1, OP, 8, 8, 9, 0, 0, 1, 2, 2, k + 1));
    end
    rows.push_back(mk(0, 1, LD, 1, 0, 8, 0, 0, 1, 0, 0, 4));
    rows.push_back(mk(1, 1, OP, 8, 8, 9, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, OP, 8, 8, 9, 0, 0, 1, 0, 0, 0));
    foreach (rows[i]) begin
      row_t e;
      apply(rows[i]);
      #1;
      checks++;
      if (stall !== rows[i].st || flush_if_id !== rows[i].br) begin
        failures++;
        $display("FAIL sat.comb row %0d: stall=%b flush=%b want %b %b", i, stall, flush_if_id, rows[i].st, rows[i].br);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({ex_valid, fwd_a_sel, fwd_b_sel} !== {e.ev, e.ea, e.eb} || stall_count !== 16'(e.ec)) begin
        failures++;
        $display("FAIL sat.regs row %0d: ev=%b a=%b b=%b cnt=%0d want %b %b %b %0d", i, ex_valid, fwd_a_sel, fwd_b_sel, stall_count, e.ev, e.ea, e.eb, e.ec);
      end
      checks++;
      if (cnt2 !== 2'(e.ec > 3 ? 3 : e.ec)) begin
        failures++;
        $display("FAIL sat.cnt2 row %0d: got %0d want %0d", i, cnt2, (e.ec > 3 ? 3 : e.ec));
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_x0_store();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequencing controller for the 5-stage integer pipeline (IF/ID/EX/MEM/WB). It keeps a per-stage shadow record of in-flight destination registers and generates four things:
- load-use stalls
- branch flushes
- registered forwarding selects for the EX-stage ALU operand muxes
- a saturating stall counter
It sits beside the opcode decoder and steers the pipeline-register enables and the operand muxes.

Parameters:
REG_ADDR_W, 5, register index width (32 architectural registers, x0 hard-wired zero)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous active-high reset
id_valid  input  1  ID stage holds a real instruction
id_opcode  input  7  opcode of ID instruction
id_rs1  input  REG_ADDR_W  rs1 field of ID instruction
id_rs2  input  REG_ADDR_W  rs2 field of ID instruction
id_rd  input  REG_ADDR_W  rd field of ID instruction
ex_branch_taken  input  1  EX stage resolved a taken branch/jump this cycle
stall  output  1  combinational; hold PC and IF/ID register, inject bubble into EX
flush_if_id  output  1  combinational; clear IF/ID register (equals ex_branch_taken)
ex_valid  output  1  registered; instruction now in EX is real (0 = bubble)
fwd_a_sel  output  2  registered; EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
fwd_b_sel  output  2  registered; EX operand B source, same encoding
stall_count  output  STALL_CNT_W  registered; number of load-use stall cycles, saturates at all-ones

Behaviour:
- Opcode classes:
  - OP 0110011 writes rd and uses rs1 and rs2.
  - OP-IMM 0010011 writes rd and uses rs1.
  - LOAD 0000011 writes rd, uses rs1 and is_load=1.
  - STORE 0100011 does not write and uses rs1 and rs2.
  - Any other opcode writes nothing, uses nothing, and never causes a hazard.
- Stage records: EX, MEM and WB each hold {valid, rd, reg_w, is_load}. A record with rd==0 is treated as reg_w=0.
- Load-use hazard: stall=1 when all of the following hold:
  - id_valid
  - EX record is valid, reg_w and is_load
  - EX.rd matches a used source of the ID instruction
  - ex_branch_taken=0
  A load-use stall lasts exactly one cycle.
- Clock edge, normal case (no stall, no branch):
  - EX record <= decoded ID instruction, with valid=id_valid.
  - MEM <= EX.
  - WB <= MEM.
  - ex_valid <= id_valid.
- Clock edge with stall=1:
  - EX record <= bubble (valid=0, reg_w=0).
  - ex_valid <= 0 and fwd_*_sel <= 00.
  - MEM <= EX and WB <= MEM (older instructions keep moving).
  - stall_count increments unless it is all-ones.
- Clock edge with ex_branch_taken=1:
  - Same bubble insertion into EX; the ID instruction is discarded.
  - stall is forced 0; branch has priority over load-use.
  - flush_if_id=1 in the same cycle.
  - stall_count is not incremented.
- Forwarding, computed from ID sources and registered into fwd_*_sel with the EX record load. Per used source s (unused source gives 00):
  - 01 if EX record is valid, reg_w, EX.rd==s and not is_load.
  - Otherwise 10 if MEM record is valid, reg_w and MEM.rd==s.
  - Otherwise 00.
  - The younger producer (EX record) wins over MEM.
  - s==0 always gives 00.
- A matching WB-record producer needs no forwarding: the register file is write-before-read.
- Reset (rst=1 at clock edge):
  - All stage records invalid.
  - ex_valid=0, fwd_a_sel=fwd_b_sel=00, stall_count=0.
  - stall and flush_if_id follow their inputs (0 while records are invalid).
- Reset mid-stall clears everything; no stall is pending afterward.

Decomposition:
- Shared package: opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE), forwarding encoding constants (FWD_RF, FWD_MEM, FWD_WB), and the stage-record struct typedef.
- One natural sub-module: hz_opc_class, a combinational opcode-to-{reg_w, is_load, uses_rs1, uses_rs2} decoder. It is instantiated once for the ID instruction.

Test Plan:
- ALU back-to-back: add x5 then add x6,x5,x1 -> no stall; second instruction arrives in EX with fwd_a_sel=01, fwd_b_sel=00.
- Distance-2 dependency: add x5, nop, sub x7,x2,x5 -> sub arrives in EX with fwd_b_sel=10, stall never asserted.
- Load-use: lw x8 then add x9,x8,x8 -> stall=1 for exactly one cycle and ex_valid=0 that cycle. Next edge: add in EX with fwd_a_sel=fwd_b_sel=10. stall_count goes 0 -> 1.
- Branch beats stall: lw x8 in EX with dependent add in ID, and ex_branch_taken=1 in the same cycle -> stall=0, flush_if_id=1, ex_valid=0 next cycle, stall_count unchanged.
- x0 and store: lw x0 then add x1,x0,x0 -> no stall. sw x3 rs2=x3 after add x3 -> fwd_b_sel=01, and the store never appears as a producer.
- Saturation and reset: with STALL_CNT_W=2, four load-use events -> stall_count holds 3. Assert rst during a stall cycle -> all outputs 0 on the next edge.
